// File: rtl/_bus_arbiter.sv
// -----------------------------------------------------------------------------
// _bus_arbiter
// Round-robin arbiter funnelling four valid/ready requesters into one
// registered output slot. One word per cycle is sustained while the consumer
// keeps out_ready high: a new word is taken in the same cycle as the held
// word leaves.
//
// Ports
//   clk        : rising-edge clock for all state
//   reset      : synchronous, active-high reset
//   req_valid  : per-requester request (bit i = requester i has a word)
//   req_data   : packed words, requester i at [i*WIDTH +: WIDTH]
//   req_ready  : one-hot accept strobe (combinational)
//   out_valid  : output slot holds a word
//   out_data   : registered output word
//   out_ready  : consumer takes out_data this cycle
//   grant      : one-hot owner of out_data, 0000 when the slot is empty
//   sel        : binary index of the last accepted requester
//   xfer_count : completed output handshakes, wraps at 16 bits
//
// state | meaning
// ------+------------------------------------------------------
// IDLE  | output slot empty, out_valid=0
// BUSY  | output slot holds a word, out_valid=1
// -----------------------------------------------------------------------------
module _bus_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         req_valid,
  input  logic [4*WIDTH-1:0] req_data,
  output logic [3:0]         req_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  input  logic               out_ready,
  output logic [3:0]         grant,
  output logic [1:0]         sel,
  output logic [15:0]        xfer_count
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state;
  logic   [1:0]       last;
  logic   [1:0]       win;
  logic               found;
  logic   [1:0]       idx;
  logic               slot_open;
  logic               accept;
  logic               handshake;

  // Search order last+1, last+2, last+3, last; k=4 wraps back onto last.
  always_comb begin
    found = 1'b0;
    win   = 2'd0;
    idx   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + k[1:0];
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // A held word leaving this cycle frees the slot for a same-cycle accept,
  // which also guarantees the owner is never accepted twice while stalled.
  assign slot_open = (state == IDLE) || out_ready;
  assign accept    = !reset && slot_open && found;
  assign handshake = (state == BUSY) && out_ready;
  assign req_ready = accept ? (4'b0001 << win) : 4'b0000;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      out_data   <= '0;
      grant      <= 4'b0000;
      sel        <= 2'd0;
      last       <= 2'd3;
      xfer_count <= 16'd0;
    end else begin
      if (handshake) begin
        xfer_count <= xfer_count + 16'd1;
      end
      if (accept) begin
        state     <= BUSY;
        out_valid <= 1'b1;
        out_data  <= req_data[win*WIDTH +: WIDTH];
        grant     <= 4'b0001 << win;
        sel       <= win;
        last      <= win;
      end else if (handshake) begin
        // out_data keeps its last value; only validity and ownership drop.
        state     <= IDLE;
        out_valid <= 1'b0;
        grant     <= 4'b0000;
      end
    end
  end

endmodule

// File: doc/_bus_arbiter.md
_BUS_ARBITER -- requirements
Module: _bus_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning data word width in bits.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset, sampled on rising clk edge.
REQ-004 SHALL have port req_valid  input  4  per-requester request; bit i = requester i has a word.
REQ-005 SHALL have port req_data  input  4*WIDTH  packed words; requester i at bits [i*WIDTH +: WIDTH].
REQ-006 SHALL have port req_ready  output  4  one-hot accept strobe; bit i high = requester i word taken this cycle.
REQ-007 SHALL have port out_valid  output  1  shared output holds a valid word.
REQ-008 SHALL have port out_data  output  WIDTH  shared output word.
REQ-009 SHALL have port out_ready  input  1  consumer accepts out_data this cycle.
REQ-010 SHALL have port grant  output  4  one-hot owner of the current out_data; 0000 when out_valid=0.
REQ-011 SHALL have port sel  output  2  binary index of the last accepted requester (mux select).
REQ-012 SHALL have port xfer_count  output  16  count of completed output handshakes.

Function
REQ-013 SHALL implement two states: IDLE (out_valid=0) and BUSY (out_valid=1, registered word held).
REQ-014 SHALL define "slot open" as state==IDLE, or state==BUSY with out_ready=1.
REQ-015 SHALL, when slot open and req_valid!=0, pick winner w by round-robin: first i with req_valid[i]=1 searching last+1, last+2, last+3, last (mod 4).
REQ-016 SHALL assert req_ready[w]=1 combinationally in that cycle; all other req_ready bits 0; req_ready=0000 when slot not open or req_valid=0000.
REQ-017 SHALL, on that clk edge, load req_data[w] into the output register, set sel<=w, last<=w, state<=BUSY.
REQ-018 SHALL, in BUSY with out_ready=1 and req_valid=0000, go to IDLE on the next edge.
REQ-019 SHALL, in BUSY with out_ready=0, hold out_data, grant, sel and state unchanged (no data change under backpressure).
REQ-020 SHALL sustain one word per cycle when out_ready=1 and requests are continuous (back-to-back accept during handshake).
REQ-021 SHALL drive out_data and grant from registers only; latency from req_ready pulse to out_valid = 1 cycle.
REQ-022 SHALL drive grant = one-hot(sel) when BUSY, 0000 when IDLE.
REQ-023 SHALL increment xfer_count by 1 on each cycle with out_valid=1 and out_ready=1; wrap 0xFFFF -> 0x0000.
REQ-024 SHALL ignore out_ready while IDLE (no count, no state change).
REQ-025 SHALL treat a req_valid bit dropped before its req_ready as withdrawn, with no side effect.
REQ-026 SHALL never accept a second word from the requester holding the output until that word's handshake completes.

Reset
REQ-027 SHALL, when reset=1 at a clk edge, set state=IDLE, out_valid=0, out_data=0, grant=0000, sel=0, last=3, xfer_count=0.
REQ-028 SHALL force req_ready=0000 during any cycle with reset=1; reset overrides simultaneous requests and handshakes.
REQ-029 SHALL discard any held word on reset mid-transfer; it is not counted.
REQ-030 SHALL give requester 0 highest priority on the first arbitration after reset.

Verification
REQ-031 SHALL cover: reset=1 one cycle with req_valid=1111 -> req_ready=0000; next cycle out_valid=0, grant=0000, xfer_count=0.
REQ-032 SHALL cover: req_valid=0001, req_data[0]=0x1234, out_ready=1 -> req_ready=0001 same cycle; next cycle out_valid=1, out_data=0x1234, grant=0001; then xfer_count=1.
REQ-033 SHALL cover: req_valid=1111 held, words 0xA000+i, out_ready=1 -> out_data sequence 0xA000,0xA001,0xA002,0xA003,0xA000, one per cycle.
REQ-034 SHALL cover: word from requester 2 in BUSY, out_ready=0 for 3 cycles with req_valid=1111 -> out_data, grant=0100 stable, req_ready=0000; on out_ready=1 requester 3 wins.
REQ-035 SHALL cover: reset asserted while BUSY with requester 1 -> next cycle out_valid=0, xfer_count=0; with req_valid=1111 after reset requester 0 wins.
